// File: rtl/mux_scan_if.sv
// Bus between the scan controller and its surroundings: handshake to the
// consumer, select/sample lines to mux_8x1, and the assembled result word.
interface mux_scan_if;
    logic       start;
    logic [7:0] mask;
    logic       mux_y;
    logic [2:0] mux_sel;
    logic       busy;
    logic       done;
    logic [7:0] data_out;

    modport master (
        output start, mask, mux_y,
        input  mux_sel, busy, done, data_out
    );

    modport slave (
        input  start, mask, mux_y,
        output mux_sel, busy, done, data_out
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Walks mux_8x1 through the enabled channels, holds each select SETTLE+1 cycles,
// samples y into a capture word and hands it over with a one-cycle done pulse.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    mux_scan_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_t     r_state, w_state_next;
    logic [7:0] r_mask, w_mask_next;
    logic [7:0] r_cap, w_cap_next;
    logic [7:0] r_data, w_data_next;
    logic [2:0] r_chan, w_chan_next;
    logic [3:0] r_cnt, w_cnt_next;

    logic [7:0] w_above;
    logic [2:0] w_first_chan;
    logic [2:0] w_next_chan;

    // Enabled channels strictly above the one currently being sampled.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_above
            assign w_above[gi] = r_mask[gi] && (3'(gi) > r_chan);
        end
    endgenerate

    always_comb begin
        w_first_chan = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (bus.mask[i]) w_first_chan = 3'(i);
        end
    end

    always_comb begin
        w_next_chan = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_above[i]) w_next_chan = 3'(i);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_mask_next  = r_mask;
        w_cap_next   = r_cap;
        w_data_next  = r_data;
        w_chan_next  = r_chan;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_mask_next = bus.mask;
                    w_cap_next  = 8'h00;
                    if (|bus.mask) begin
                        w_state_next = S_SCAN;
                        w_chan_next  = w_first_chan;
                        w_cnt_next   = 4'd0;
                    end else begin
                        w_state_next = S_DONE;
                        w_data_next  = 8'h00;
                    end
                end
            end
            S_SCAN: begin
                if (r_cnt != SETTLE_CNT) begin
                    w_cnt_next = r_cnt + 4'd1;
                end else begin
                    w_cap_next[r_chan] = bus.mux_y;
                    w_cnt_next         = 4'd0;
                    if (|w_above) begin
                        w_chan_next = w_next_chan;
                    end else begin
                        w_state_next = S_DONE;
                        w_data_next  = w_cap_next;
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mask  <= 8'h00;
            r_cap   <= 8'h00;
            r_data  <= 8'h00;
            r_chan  <= 3'd0;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_mask  <= w_mask_next;
            r_cap   <= w_cap_next;
            r_data  <= w_data_next;
            r_chan  <= w_chan_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // mux_8x1 treats sel[0] as the channel MSB, hence the bit reversal.
    assign bus.mux_sel  = (r_state == S_SCAN) ? {r_chan[0], r_chan[1], r_chan[2]} : 3'b000;
    assign bus.busy     = (r_state == S_SCAN);
    assign bus.done     = (r_state == S_DONE);
    assign bus.data_out = r_data;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: SETTLE=2 and SETTLE=0 instances each driving a
// behavioural mux_8x1; results tracked through a scoreboard queue.
module tb_mux_scan_ctrl;
    logic clk;
    logic rst;
    logic [7:0] r_in0, r_in1;

    mux_scan_if if0();
    mux_scan_if if1();

    // Behavioural mux_8x1: sel[0] is the MSB of the channel index.
    assign if0.mux_y = r_in0[{if0.mux_sel[0], if0.mux_sel[1], if0.mux_sel[2]}];
    assign if1.mux_y = r_in1[{if1.mux_sel[0], if1.mux_sel[1], if1.mux_sel[2]}];

    mux_scan_ctrl #(.SETTLE(2)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    mux_scan_ctrl #(.SETTLE(0)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] mask;
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs [8];
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] last_data [2];
    logic [7:0] sb_data [$];
    int         sb_lat [$];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] rev3(input int k);
        logic [2:0] kb;
        kb = 3'(k);
        return {kb[0], kb[1], kb[2]};
    endfunction

    function automatic logic [2:0] get_sel(input int w);
        return (w == 0) ? if0.mux_sel : if1.mux_sel;
    endfunction
    function automatic logic get_busy(input int w);
        return (w == 0) ? if0.busy : if1.busy;
    endfunction
    function automatic logic get_done(input int w);
        return (w == 0) ? if0.done : if1.done;
    endfunction
    function automatic logic [7:0] get_data(input int w);
        return (w == 0) ? if0.data_out : if1.data_out;
    endfunction

    task automatic drive(input int w, input logic [7:0] m, input logic [7:0] din, input logic st);
        if (w == 0) begin
            if0.mask = m; r_in0 = din; if0.start = st;
        end else begin
            if1.mask = m; r_in1 = din; if1.start = st;
        end
    endtask

    task automatic set_start(input int w, input logic st);
        if (w == 0) if0.start = st;
        else        if1.start = st;
    endtask

    // One complete scan; optional second start + mask change while busy.
    task automatic run_scan(input int w, input logic [7:0] m, input logic [7:0] din,
                            input logic [7:0] exp, input bit disturb);
        int         s1;
        int         chans[$];
        int         lat;
        int         exp_lat;
        bit         got;
        bit         exp_busy;
        logic [2:0] exp_sel;
        logic [7:0] exp_d;
        int         extra;
        s1 = (w == 0) ? 3 : 1;
        for (int k = 0; k < 8; k++) if (m[k]) chans.push_back(k);
        lat = chans.size() * s1 + 1;

        @(negedge clk);
        check($sformatf("dut%0d data_hold", w), get_data(w), last_data[w]);
        drive(w, m, din, 1'b1);
        sb_data.push_back(exp);
        sb_lat.push_back(lat);
        @(posedge clk);
        #1 set_start(w, 1'b0);

        got = 1'b0;
        for (int c = 1; c <= lat + 5 && !got; c++) begin
            @(negedge clk);
            exp_busy = (c < lat);
            exp_sel  = exp_busy ? rev3(chans[(c - 1) / s1]) : 3'b000;
            check($sformatf("dut%0d m=%02h c%0d busy", w, m, c), get_busy(w), exp_busy);
            check($sformatf("dut%0d m=%02h c%0d sel", w, m, c), get_sel(w), exp_sel);
            if (get_done(w)) begin
                got = 1'b1;
                if (sb_data.size() == 0) begin
                    check($sformatf("dut%0d unexpected_done", w), 1, 0);
                end else begin
                    exp_d   = sb_data.pop_front();
                    exp_lat = sb_lat.pop_front();
                    check($sformatf("dut%0d m=%02h done_cycle", w, m), c, exp_lat);
                    check($sformatf("dut%0d m=%02h data_out", w, m), get_data(w), exp_d);
                    last_data[w] = exp_d;
                end
                $display("scan dut%0d mask=%02h in=%02h -> data_out=%02h at cycle %0d",
                         w, m, din, get_data(w), c);
            end
            if (disturb && c == 4) drive(w, 8'hFF, din, 1'b1);
            if (disturb && c == 5) set_start(w, 1'b0);
        end
        if (!got) check($sformatf("dut%0d m=%02h done_timeout", w, m), 0, 1);

        @(negedge clk);
        check($sformatf("dut%0d m=%02h done_single", w, m), get_done(w), 0);
        if (disturb) begin
            extra = 0;
            repeat (30) begin
                @(negedge clk);
                if (get_done(w)) extra++;
            end
            check($sformatf("dut%0d extra_done", w), extra, 0);
        end
    endtask

    initial begin
        vecs[0] = '{mask: 8'hFF, din: 8'hA5, exp: 8'hA5};
        vecs[1] = '{mask: 8'h00, din: 8'hFF, exp: 8'h00};
        vecs[2] = '{mask: 8'h81, din: 8'hFF, exp: 8'h81};
        vecs[3] = '{mask: 8'h0F, din: 8'h5A, exp: 8'h0A};
        vecs[4] = '{mask: 8'hF0, din: 8'h5A, exp: 8'h50};
        vecs[5] = '{mask: 8'h24, din: 8'hFF, exp: 8'h24};
        vecs[6] = '{mask: 8'h10, din: 8'h10, exp: 8'h10};
        vecs[7] = '{mask: 8'hFF, din: 8'hA5, exp: 8'hA5};

        rst = 1'b1;
        drive(0, 8'h00, 8'h00, 1'b0);
        drive(1, 8'h00, 8'h00, 1'b0);
        last_data[0] = 8'h00;
        last_data[1] = 8'h00;
        repeat (2) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            check($sformatf("dut%0d reset sel", w), get_sel(w), 0);
            check($sformatf("dut%0d reset busy", w), get_busy(w), 0);
            check($sformatf("dut%0d reset done", w), get_done(w), 0);
            check($sformatf("dut%0d reset data", w), get_data(w), 0);
        end
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_scan(0, vecs[i].mask, vecs[i].din, vecs[i].exp, 1'b0);

        // Empty mask must overwrite the previous nonzero result.
        run_scan(0, 8'h00, 8'hFF, 8'h00, 1'b0);

        // Second start and mask change while busy are ignored.
        run_scan(0, 8'h0F, 8'hFF, 8'h0F, 1'b1);

        // Asynchronous reset in cycle 10 of a full scan.
        run_scan(0, 8'hFF, 8'hA5, 8'hA5, 1'b0);
        @(negedge clk);
        drive(0, 8'hFF, 8'h3C, 1'b1);
        @(posedge clk);
        #1 set_start(0, 1'b0);
        repeat (10) @(negedge clk);
        check("dut0 pre_reset busy", get_busy(0), 1);
        #1 rst = 1'b1;
        #1;
        check("dut0 async_rst sel", get_sel(0), 0);
        check("dut0 async_rst busy", get_busy(0), 0);
        check("dut0 async_rst done", get_done(0), 0);
        check("dut0 async_rst data", get_data(0), 0);
        $display("reset mid-scan: sel=%0b busy=%0b data_out=%02h", get_sel(0), get_busy(0), get_data(0));
        @(negedge clk);
        rst = 1'b0;
        last_data[0] = 8'h00;
        last_data[1] = 8'h00;
        run_scan(0, 8'hFF, 8'h3C, 8'h3C, 1'b0);

        // SETTLE=0 instance.
        run_scan(1, 8'hFF, 8'h3C, 8'h3C, 1'b0);
        run_scan(1, 8'h81, 8'hFF, 8'h81, 1'b0);
        run_scan(1, 8'h00, 8'hFF, 8'h00, 1'b0);
        run_scan(1, 8'h5A, 8'hF0, 8'h50, 1'b0);

        check("scoreboard_empty", sb_data.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end
endmodule
